regfile_mp: RTL and testbench

Parametrised multi-read-port CPU register file with a per-register busy scoreboard.
- Sits between decode (read operands, issue destination) and writeback (write result).
- Keeps the one-cycle registered read of the existing file.
- Adds: N read ports, write-to-read bypass, hardwired zero register, async clear, pending-write tracking for hazard detection.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register file: default widths, the
// hardwired-zero index, packed-port slicing and the busy-bit update rule.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;

  // Action applied to one busy bit at a clock edge.
  typedef enum logic [1:0] {
    BUSY_HOLD = 2'd0,
    BUSY_SET  = 2'd1,
    BUSY_CLR  = 2'd2
  } busy_op_e;

  // Low bit of port p inside a packed multi-port bus of lanes 'width' wide.
  function automatic int port_lo(input int p, input int width);
    return p * width;
  endfunction

  // Issue wins over retire: a new producer issued on the same edge the old
  // one writes back leaves the register pending.
  function automatic busy_op_e busy_sel(input logic set_hit, input logic clr_hit);
    if (set_hit)      return BUSY_SET;
    else if (clr_hit) return BUSY_CLR;
    else              return BUSY_HOLD;
  endfunction

  function automatic logic busy_apply(input busy_op_e op, input logic cur);
    case (op)
      BUSY_SET: return 1'b1;
      BUSY_CLR: return 1'b0;
      default:  return cur;
    endcase
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker. Exposes the next-state busy vector so
// the read ports can report a busy flag that already reflects this edge's
// issue and writeback.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  busy_set,
  input  logic [ADDR_W-1:0]     busy_addr,
  input  logic                  clr_en,
  input  logic [ADDR_W-1:0]     clr_addr,
  output logic [(1<<ADDR_W)-1:0] busy_next
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;

  // Next-state busy bit for every index; the zero register is never pending.
  always_comb begin
    busy_next = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      busy_next[i] = busy_apply(busy_sel(busy_set && (busy_addr == ADDR_W'(i)),
                                         clr_en   && (clr_addr  == ADDR_W'(i))),
                                busy_q[i]);
      if ((ZERO_REG != 0) && (i == ZERO_IDX)) begin
        busy_next[i] = 1'b0;
      end
    end
  end

  // Busy state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port CPU register file with registered reads, optional
// write-to-read bypass, optional hardwired zero register and a busy
// scoreboard used by decode for hazard detection.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic [DEPTH-1:0]  busy_next;

  // A write to the hardwired zero register is dropped everywhere, including
  // the bypass path.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_IDX)));

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .clr_en    (wr_en),
    .clr_addr  (wr_addr),
    .busy_next (busy_next)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    localparam int A_LO = port_lo(p, ADDR_W);
    localparam int D_LO = port_lo(p, DATA_W);

    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic              busy_p0;
    logic [DATA_W-1:0] data_p1;
    logic              busy_p1;

    assign addr_p0 = rd_addr[A_LO +: ADDR_W];

    // Stage p0: select array contents, forwarded write data or zero.
    always_comb begin
      data_p0 = regs[addr_p0];
      if ((BYPASS != 0) && wr_ok && (wr_addr == addr_p0)) begin
        data_p0 = wr_data;
      end
      if ((ZERO_REG != 0) && (addr_p0 == ADDR_W'(ZERO_IDX))) begin
        data_p0 = '0;
      end
      busy_p0 = busy_next[addr_p0];
    end

    // Stage p1: registered read result, held while the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_p1 <= '0;
        busy_p1 <= 1'b0;
      end else if (rd_en[p]) begin
        data_p1 <= data_p0;
        busy_p1 <= busy_p0;
      end
    end

    assign rd_data[D_LO +: DATA_W] = data_p1;
    assign rd_busy[p]              = busy_p1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp with a queue-based scoreboard.
module tb_regfile_mp;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;
  localparam int ZERO_REG = 1;
  localparam int BYPASS   = 1;
  localparam int DEPTH    = 1 << ADDR_W;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_addr;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy_set(busy_set), .busy_addr(busy_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_RD*DATA_W-1:0] d;
    logic [NUM_RD-1:0]        b;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: architectural registers, pending flags, and the value
  // each read port is currently presenting.
  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_busy [DEPTH];
  logic [DATA_W-1:0] last_d [NUM_RD];
  bit                last_b [NUM_RD];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      last_d[p] = '0;
      last_b[p] = 0;
    end
  endtask

  // Drive one cycle of stimulus, predict the outputs after the edge, push the
  // prediction, then advance the model and wait for the edge.
  task automatic step(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic bs, input logic [4:0] ba);
    bit          nbusy [DEPTH];
    logic [4:0]  addr;
    bit          write_takes;
    exp_t        e;
    @(negedge clk);
    rd_en     = en;
    rd_addr   = {a1, a0};
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    busy_set  = bs;
    busy_addr = ba;

    write_takes = we && !(ZERO_REG != 0 && wa == 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (bs && ba == i)      nbusy[i] = 1;
      else if (we && wa == i) nbusy[i] = 0;
      else                    nbusy[i] = m_busy[i];
      if (ZERO_REG != 0 && i == 0) nbusy[i] = 0;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      addr = (p == 0) ? a0 : a1;
      if (en[p]) begin
        if (ZERO_REG != 0 && addr == 0)                 last_d[p] = '0;
        else if (BYPASS != 0 && write_takes && wa == addr) last_d[p] = wd;
        else                                            last_d[p] = m_regs[addr];
        last_b[p] = nbusy[addr];
      end
      e.d[p*DATA_W +: DATA_W] = last_d[p];
      e.b[p] = last_b[p];
    end
    exp_q.push_back(e);

    if (write_takes) m_regs[wa] = wd;
    for (int i = 0; i < DEPTH; i++) m_busy[i] = nbusy[i];
    @(posedge clk);
  endtask

  task automatic idle();
    step(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Monitor: the registered read outputs are presented every edge; pop the
  // prediction for that edge and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_rd_data", 64'(rd_data), 64'(e.d));
        chk("sb_rd_busy", 64'(rd_busy), 64'(e.b));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_addr = '0;
    model_reset();
    #2;
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_rd_busy", 64'(rd_busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then dual-port read.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    step(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    chk("read_r5_p0", 64'(rd_data[31:0]),  64'h0000_0000_DEAD_BEEF);
    chk("read_r5_p1", 64'(rd_data[63:32]), 64'h0000_0000_DEAD_BEEF);

    // Same-edge write and read of r7 on port 1.
    step(2'b10, 5'd0, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    #1;
    chk("bypass_r7", 64'(rd_data[63:32]), (BYPASS != 0) ? 64'h1234_5678 : 64'd0);

    // Zero register ignores writes and busy_set.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    step(2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    chk("zero_data", 64'(rd_data[31:0]), 64'd0);
    chk("zero_busy", 64'(rd_busy[0]), 64'd0);

    // Scoreboard set/clear collision on r3.
    step(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    step(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1; chk("busy_r3_set", 64'(rd_busy[0]), 64'd1);
    step(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3);
    #1; chk("busy_r3_collide", 64'(rd_busy[0]), 64'd1);
    step(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 32'h34, 1'b0, 5'd0);
    #1; chk("busy_r3_clear", 64'(rd_busy[0]), 64'd0);

    // Idle port holds its last read.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd2, 32'hA, 1'b0, 5'd0);
    step(2'b01, 5'd2, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1; chk("hold_first", 64'(rd_data[31:0]), 64'hA);
    step(2'b00, 5'd2, 5'd0, 1'b1, 5'd2, 32'hB, 1'b0, 5'd0);
    #1; chk("hold_idle", 64'(rd_data[31:0]), 64'hA);
    step(2'b01, 5'd2, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1; chk("hold_reread", 64'(rd_data[31:0]), 64'hB);

    // Asynchronous reset mid-cycle with non-zero outputs.
    step(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step(2'b11, 5'd9, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", 64'(rd_data), 64'd0);
    chk("async_rst_busy", 64'(rd_busy), 64'd0);
    rd_en = 2'b11;
    @(posedge clk);
    #1;
    chk("rst_hold_data", 64'(rd_data), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 5'd5, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step(2'b11, 5'd2, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    // Randomised traffic, indices biased low to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom_range(0, 3)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end
    idle();
    @(posedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
